// File: rtl/clkctrl_pkg.sv
// Shared types and helpers for the clock-switch sequencer.
// State encoding, divider select codes and a constant-evaluable clog2.
package clkctrl_pkg;

    typedef enum logic [1:0] {
        ST_LS     = 2'b00,
        ST_HS_REQ = 2'b01,
        ST_HS     = 2'b10,
        ST_LS_REQ = 2'b11
    } state_t;

    localparam logic [1:0] DIV1 = 2'b00;
    localparam logic [1:0] DIV2 = 2'b01;
    localparam logic [1:0] DIV4 = 2'b10;

    // Number of bits needed to index 'value' distinct codes.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/clksel_seq_sync_bits.sv
// Multi-flop synchroniser for one asynchronous feedback bit.
// The reset value lets each feedback line come up in its "idle" sense.
module sync_bits #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_b,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) chain <= {DEPTH{RST_VAL}};
        else        chain <= {chain[DEPTH-2:0], d};
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/clksel_seq.sv
// Clock-switch sequencer: turns speed/divider requests into glitch-free switch
// controls, closing the loop on the switch's synchronised acknowledge feedback.
module clksel_seq
    import clkctrl_pkg::*;
#(
    parameter int         SYNC_DEPTH = 2,
    parameter int         HOLDOFF    = 4,
    parameter int         TIMEOUT    = 64,
    parameter int         CNT_W      = 8,
    parameter logic [1:0] DIV_RST    = DIV1
) (
    input  logic             lsclk_in,
    input  logic             rst_b,
    input  logic             req_hs,
    input  logic [1:0]       req_div,
    input  logic             hsclk_selected,
    input  logic             lsclk_selected,
    input  logic             err_clr,
    output logic             hsclk_sel,
    output logic [1:0]       cpuclk_div_sel,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] switch_cnt
);

    localparam int TMAX = (HOLDOFF > TIMEOUT) ? HOLDOFF : TIMEOUT;
    localparam int TW   = (clog2(TMAX + 1) < 1) ? 1 : clog2(TMAX + 1);
    localparam logic [TW-1:0] T_HOLD = TW'(HOLDOFF);
    localparam logic [TW-1:0] T_TOUT = TW'(TIMEOUT);

    logic hs_ack;
    logic ls_ack;

    sync_bits #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b0)) u_sync_hs (
        .clk   (lsclk_in),
        .rst_b (rst_b),
        .d     (hsclk_selected),
        .q     (hs_ack)
    );

    sync_bits #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b1)) u_sync_ls (
        .clk   (lsclk_in),
        .rst_b (rst_b),
        .d     (lsclk_selected),
        .q     (ls_ack)
    );

    state_t           state, state_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic             sel_nxt;
    logic [1:0]       div_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             err_set;
    logic             timer_zero;
    logic             div_diff;

    assign timer_zero = (timer == '0);
    assign div_diff   = (req_div != cpuclk_div_sel);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer_zero ? '0 : timer - TW'(1);
        sel_nxt   = hsclk_sel;
        div_nxt   = cpuclk_div_sel;
        cnt_nxt   = switch_cnt;
        err_set   = 1'b0;
        case (state)
            ST_LS: begin
                // The divider may only move while the LS clock is running the CPU.
                if (div_diff) begin
                    div_nxt   = req_div;
                    timer_nxt = T_HOLD;
                end else if (req_hs && timer_zero && ls_ack) begin
                    state_nxt = ST_HS_REQ;
                    sel_nxt   = 1'b1;
                    timer_nxt = T_TOUT;
                end
            end
            ST_HS_REQ: begin
                if (hs_ack) begin
                    state_nxt = ST_HS;
                    timer_nxt = T_HOLD;
                    cnt_nxt   = switch_cnt + CNT_W'(1);
                end else if (timer_zero) begin
                    err_set   = 1'b1;
                    sel_nxt   = 1'b0;
                    state_nxt = ST_LS_REQ;
                    timer_nxt = T_TOUT;
                end
            end
            ST_HS: begin
                if ((!req_hs || div_diff) && timer_zero) begin
                    state_nxt = ST_LS_REQ;
                    sel_nxt   = 1'b0;
                    timer_nxt = T_TOUT;
                end
            end
            ST_LS_REQ: begin
                if (ls_ack && !hs_ack) begin
                    state_nxt = ST_LS;
                    timer_nxt = T_HOLD;
                end else if (timer_zero) begin
                    err_set = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_LS_REQ;
                sel_nxt   = 1'b0;
                timer_nxt = T_TOUT;
            end
        endcase
    end

    always_ff @(posedge lsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            state          <= ST_LS;
            timer          <= T_HOLD;
            hsclk_sel      <= 1'b0;
            cpuclk_div_sel <= DIV_RST;
            timeout_err    <= 1'b0;
            switch_cnt     <= '0;
        end else begin
            state          <= state_nxt;
            timer          <= timer_nxt;
            hsclk_sel      <= sel_nxt;
            cpuclk_div_sel <= div_nxt;
            timeout_err    <= err_set | (timeout_err & ~err_clr);
            switch_cnt     <= cnt_nxt;
        end
    end

    assign busy = (state == ST_HS_REQ) || (state == ST_LS_REQ);

endmodule

// File: tb/tb_clksel_seq.sv
// Bench for clksel_seq: a deadline-based reference model feeds a scoreboard queue,
// a monitor compares every cycle, and directed phases time the key transitions.
module tb_clksel_seq;

    localparam int SD = 2;
    localparam int HO = 4;
    localparam int TO = 64;

    logic       lsclk_in = 1'b0;
    logic       rst_b = 1'b0;
    logic       req_hs = 1'b0;
    logic [1:0] req_div = 2'b00;
    logic       hsclk_selected = 1'b0;
    logic       lsclk_selected = 1'b1;
    logic       err_clr = 1'b0;

    logic       hsclk_sel, busy, timeout_err;
    logic [1:0] cpuclk_div_sel;
    logic [7:0] switch_cnt;
    logic       hsclk_sel2, busy2, timeout_err2;
    logic [1:0] div2;
    logic [1:0] switch_cnt2;

    int n_checks = 0;
    int n_errors = 0;
    int n_sb = 0;

    always #5 lsclk_in = ~lsclk_in;

    clksel_seq #(.SYNC_DEPTH(SD), .HOLDOFF(HO), .TIMEOUT(TO), .CNT_W(8), .DIV_RST(2'b00)) u_dut (
        .lsclk_in(lsclk_in), .rst_b(rst_b), .req_hs(req_hs), .req_div(req_div),
        .hsclk_selected(hsclk_selected), .lsclk_selected(lsclk_selected), .err_clr(err_clr),
        .hsclk_sel(hsclk_sel), .cpuclk_div_sel(cpuclk_div_sel), .busy(busy),
        .timeout_err(timeout_err), .switch_cnt(switch_cnt)
    );

    clksel_seq #(.SYNC_DEPTH(SD), .HOLDOFF(HO), .TIMEOUT(TO), .CNT_W(2), .DIV_RST(2'b00)) u_dut2 (
        .lsclk_in(lsclk_in), .rst_b(rst_b), .req_hs(req_hs), .req_div(req_div),
        .hsclk_selected(hsclk_selected), .lsclk_selected(lsclk_selected), .err_clr(err_clr),
        .hsclk_sel(hsclk_sel2), .cpuclk_div_sel(div2), .busy(busy2),
        .timeout_err(timeout_err2), .switch_cnt(switch_cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
            if (n_errors >= 40) begin
                $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
                $finish;
            end
        end
    endtask

    // Clock switch stand-in: follows hsclk_sel after sw_lat edges; when dead, HS never acks.
    int   sw_lat = 3;
    logic sw_dead = 1'b0;
    logic last_sel = 1'b0;
    int   age = 0;
    always begin
        @(posedge lsclk_in);
        #1;
        if (hsclk_sel == last_sel) age++;
        else begin
            last_sel = hsclk_sel;
            age      = 1;
        end
        if (age >= sw_lat) begin
            hsclk_selected = last_sel & ~sw_dead;
            lsclk_selected = ~(last_sel & ~sw_dead);
        end
    end

    // Reference model: waits are tracked as "edges since the last (re)start" rather
    // than a down-counter; a wait of W has expired once more than W edges have passed.
    typedef struct packed {
        logic       sel;
        logic [1:0] div;
        logic       busy;
        logic       err;
        logic [7:0] cnt;
    } snap_t;

    localparam int M_LS = 0, M_HS_REQ = 1, M_HS = 2, M_LS_REQ = 3;

    snap_t      exp_q[$];
    logic       hs_q[$];
    logic       ls_q[$];
    int         m_mode = M_LS;
    int         n_edge = 0;
    int         mark = 0;
    int         m_cnt = 0;
    logic       m_sel = 1'b0;
    logic       m_err = 1'b0;
    logic [1:0] m_div = 2'b00;

    always @(posedge lsclk_in) begin : model
        logic hs_a, ls_a, set_err;
        int   el;
        n_edge++;
        if (!rst_b) begin
            m_mode = M_LS;
            mark   = n_edge;
            m_sel  = 1'b0;
            m_div  = 2'b00;
            m_err  = 1'b0;
            m_cnt  = 0;
            hs_q   = {};
            ls_q   = {};
            repeat (SD) begin
                hs_q.push_back(1'b0);
                ls_q.push_back(1'b1);
            end
        end else begin
            hs_a = hs_q.pop_front();
            ls_a = ls_q.pop_front();
            hs_q.push_back(hsclk_selected);
            ls_q.push_back(lsclk_selected);
            el      = n_edge - mark;
            set_err = 1'b0;
            case (m_mode)
                M_LS:
                    if (req_div != m_div) begin
                        m_div = req_div;
                        mark  = n_edge;
                    end else if (req_hs && el > HO && ls_a) begin
                        m_mode = M_HS_REQ; m_sel = 1'b1; mark = n_edge;
                    end
                M_HS_REQ:
                    if (hs_a) begin
                        m_mode = M_HS; mark = n_edge; m_cnt++;
                    end else if (el > TO) begin
                        set_err = 1'b1; m_sel = 1'b0; m_mode = M_LS_REQ; mark = n_edge;
                    end
                M_HS:
                    if ((!req_hs || req_div != m_div) && el > HO) begin
                        m_mode = M_LS_REQ; m_sel = 1'b0; mark = n_edge;
                    end
                default:
                    if (ls_a && !hs_a) begin
                        m_mode = M_LS; mark = n_edge;
                    end else if (el > TO) set_err = 1'b1;
            endcase
            m_err = set_err | (m_err & ~err_clr);
        end
        exp_q.push_back('{sel: m_sel, div: m_div,
                          busy: (m_mode == M_HS_REQ || m_mode == M_LS_REQ),
                          err: m_err, cnt: 8'(m_cnt)});
    end

    always @(negedge lsclk_in) begin : monitor
        snap_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rst_b) begin
                n_sb++;
                check("scoreboard", 32'({hsclk_sel, cpuclk_div_sel, busy, timeout_err, switch_cnt}), 32'(e));
                check("scoreboard_cntw2", 32'({hsclk_sel2, div2, busy2, timeout_err2, switch_cnt2}),
                      32'({e.sel, e.div, e.busy, e.err, e.cnt[1:0]}));
            end
        end
    end

    // Counts edges until the selected signal equals val; sig 5 is "idle in LS".
    task automatic wait_for(input int sig, input logic [1:0] val, input int budget,
                            input string name, output int n);
        logic [1:0] cur;
        n = 0;
        forever begin
            @(posedge lsclk_in);
            n++;
            @(negedge lsclk_in);
            case (sig)
                0:       cur = {1'b0, hsclk_sel};
                1:       cur = {1'b0, busy};
                2:       cur = {1'b0, timeout_err};
                3:       cur = {1'b0, hsclk_selected};
                4:       cur = cpuclk_div_sel;
                default: cur = {1'b0, hsclk_sel | busy};
            endcase
            if (cur == val) return;
            if (n >= budget) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s: no event within %0d cycles", name, budget);
                return;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   edges;
        int   last_edge;
        logic prev;

        repeat (3) @(posedge lsclk_in);
        @(negedge lsclk_in);
        check("rst_hsclk_sel", 32'(hsclk_sel), 32'd0);
        check("rst_div", 32'(cpuclk_div_sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(timeout_err), 32'd0);
        check("rst_cnt", 32'(switch_cnt), 32'd0);

        // Start-up: holdoff of HO counted down, hsclk_sel rises on the following edge.
        req_hs = 1'b1;
        @(posedge lsclk_in);
        #1 rst_b = 1'b1;
        wait_for(0, 2'd1, 50, "first_rise", n);
        check("first_rise_edge", 32'(n), 32'(HO + 1));
        wait_for(3, 2'd1, 50, "first_ack_in", n);
        wait_for(1, 2'd0, 50, "first_hs_entry", n);
        check("hs_entry_latency", 32'(n), 32'(SD + 1));
        check("cnt_after_first", 32'(switch_cnt), 32'd1);

        // Divider change while in HS forces a round trip through LS.
        req_div = 2'b01;
        wait_for(0, 2'd0, 100, "div_hs_drop", n);
        check("div_held_in_hs", 32'(cpuclk_div_sel), 32'd0);
        wait_for(4, 2'd1, 100, "div_load", n);
        check("div_load_in_ls", 32'({hsclk_sel, busy}), 32'd0);
        wait_for(0, 2'd1, 100, "div_rise", n);
        check("div_to_rise_edges", 32'(n), 32'(HO + 1));
        wait_for(1, 2'd0, 100, "div_hs_entry", n);
        check("cnt_after_div", 32'(switch_cnt), 32'd2);

        // Dead switch: timer loaded with TO at the rise, expiry seen one edge after reaching 0.
        req_hs = 1'b0;
        wait_for(5, 2'd0, 200, "leave_hs", n);
        sw_dead = 1'b1;
        req_hs  = 1'b1;
        wait_for(0, 2'd1, 100, "dead_rise", n);
        wait_for(2, 2'd1, 200, "timeout", n);
        check("timeout_edges", 32'(n), 32'(TO + 1));
        check("timeout_drops_sel", 32'(hsclk_sel), 32'd0);
        check("timeout_busy", 32'(busy), 32'd1);
        req_hs = 1'b0;
        wait_for(1, 2'd0, 10, "ls_after_timeout", n);
        check("ls_after_timeout_edges", 32'(n), 32'd1);
        check("err_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        @(posedge lsclk_in);
        @(negedge lsclk_in);
        err_clr = 1'b0;
        check("err_cleared", 32'(timeout_err), 32'd0);
        sw_dead = 1'b0;

        // Fast request toggling must never shorten the spacing of hsclk_sel edges.
        edges     = 0;
        last_edge = 0;
        prev      = hsclk_sel;
        for (int i = 0; i < 400; i++) begin
            if (i % 2 == 0) req_hs = ~req_hs;
            @(posedge lsclk_in);
            @(negedge lsclk_in);
            if (hsclk_sel != prev) begin
                if (edges > 0) check("toggle_gap_ok", 32'(i - last_edge >= HO + SD + 2), 32'd1);
                edges++;
                last_edge = i;
                prev      = hsclk_sel;
            end
        end
        check("toggle_edges_seen", 32'(edges >= 4), 32'd1);

        // Reset pulse in HS_REQ with a non-default divider in place.
        req_hs = 1'b0;
        wait_for(5, 2'd0, 300, "idle_before_rst", n);
        sw_lat  = 6;
        req_div = 2'b10;
        wait_for(4, 2'd2, 100, "div_10_load", n);
        req_hs = 1'b1;
        wait_for(0, 2'd1, 100, "rise_before_rst", n);
        check("in_hs_req_before_rst", 32'(busy), 32'd1);
        @(posedge lsclk_in);
        #1 rst_b = 1'b0;
        #1;
        check("midrst_hsclk_sel", 32'(hsclk_sel), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cnt", 32'(switch_cnt), 32'd0);
        check("midrst_div", 32'(cpuclk_div_sel), 32'd0);
        check("midrst_cnt_w2", 32'(switch_cnt2), 32'd0);
        repeat (2) @(posedge lsclk_in);
        #1 rst_b = 1'b1;
        sw_lat = 3;

        // Five complete switches after reset; the 2-bit counter wraps to 1.
        for (int k = 0; k < 5; k++) begin
            req_hs = 1'b1;
            wait_for(0, 2'd1, 100, "sw_rise", n);
            wait_for(1, 2'd0, 100, "sw_hs_entry", n);
            req_hs = 1'b0;
            wait_for(5, 2'd0, 100, "sw_back_ls", n);
        end
        check("cnt_after_five", 32'(switch_cnt), 32'd5);
        check("cnt_w2_wrapped", 32'(switch_cnt2), 32'd1);

        // Randomised traffic, checked cycle by cycle through the scoreboard.
        for (int i = 0; i < 3000; i++) begin
            @(negedge lsclk_in);
            if ($urandom_range(0, 15) == 0) req_hs = ~req_hs;
            if ($urandom_range(0, 99) == 0) req_div = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) sw_lat = $urandom_range(1, 6);
            if ($urandom_range(0, 299) == 0) sw_dead = ~sw_dead;
            err_clr = ($urandom_range(0, 29) == 0);
        end
        err_clr = 1'b0;
        repeat (3) @(negedge lsclk_in);
        check("scoreboard_active", 32'(n_sb >= 3000), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
